// File: rtl/ifft_8point_if.sv
// Stream interface for ifft_8point: serial bin input and serial sample output,
// each with its own valid/ready handshake.
interface ifft_8point_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_real;
  logic [DATA_W-1:0] in_imag;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_real;
  logic [DATA_W-1:0] out_imag;
  logic              out_last;

  modport master (
    output in_valid, in_real, in_imag, in_last, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_last
  );

  modport slave (
    input  in_valid, in_real, in_imag, in_last, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_last
  );
endinterface

// File: rtl/ifft_8point.sv
// Radix-2 DIT 8-point inverse FFT, Q1.15, in-place with one butterfly per cycle
// and 1/2 scaling per stage. Define IFFT_ROUND_EN for round-half-up shifts.
module ifft_8point #(
  parameter int DATA_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  ifft_8point_if.slave  bus,
  output logic          done,
  output logic          frame_err
);
  localparam int ACC_W = DATA_W + 2;
  localparam logic signed [DATA_W-1:0] C_45  = 16'sh5A82;
  localparam logic signed [DATA_W-1:0] C_135 = 16'shA57E;
  localparam logic signed [ACC_W-1:0]  SAT_HI = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0]  SAT_LO = -ACC_W'(32768);
`ifdef IFFT_ROUND_EN
  localparam logic signed [31:0]      TW_RND = 32'sh4000;
  localparam logic signed [ACC_W-1:0] BF_RND = ACC_W'(1);
`else
  localparam logic signed [31:0]      TW_RND = 32'sh0;
  localparam logic signed [ACC_W-1:0] BF_RND = ACC_W'(0);
`endif

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

  state_t state, state_nxt;
  logic [2:0] cnt;
  logic [1:0] stage, bfly;
  logic signed [DATA_W-1:0] mem_r [8];
  logic signed [DATA_W-1:0] mem_i [8];

  logic accept, out_fire, load_ok, compute_end;
  assign accept      = bus.in_valid & bus.in_ready;
  assign out_fire    = bus.out_valid & bus.out_ready;
  assign load_ok     = bus.in_last & (cnt == 3'd7);
  assign compute_end = (stage == 2'd2) & (bfly == 2'd3);

  assign bus.in_ready  = (state == S_LOAD) & ~rst;
  assign bus.out_valid = (state == S_OUTPUT);
  assign bus.out_last  = (state == S_OUTPUT) & (cnt == 3'd7);
  assign bus.out_real  = (state == S_OUTPUT) ? mem_r[cnt] : '0;
  assign bus.out_imag  = (state == S_OUTPUT) ? mem_i[cnt] : '0;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI)      return SAT_HI[DATA_W-1:0];
    else if (v < SAT_LO) return SAT_LO[DATA_W-1:0];
    else                 return v[DATA_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:    if (accept && load_ok)        state_nxt = S_COMPUTE;
      S_COMPUTE: if (compute_end)              state_nxt = S_OUTPUT;
      S_OUTPUT:  if (out_fire && cnt == 3'd7)  state_nxt = S_LOAD;
      default:                                 state_nxt = S_LOAD;
    endcase
  end

  // Butterfly addressing: h = 2^stage, p = (b/h)*2h + b%h, q = p + h, k = (b%h)*(4/h).
  logic [2:0] p_idx, q_idx;
  logic [1:0] k_idx;
  always_comb begin
    p_idx = {1'b0, bfly};
    q_idx = {1'b1, bfly};
    k_idx = bfly;
    case (stage)
      2'd0: begin p_idx = {bfly, 1'b0}; q_idx = {bfly, 1'b1}; k_idx = 2'd0; end
      2'd1: begin
        p_idx = {bfly[1], 1'b0, bfly[0]};
        q_idx = {bfly[1], 1'b1, bfly[0]};
        k_idx = {bfly[0], 1'b0};
      end
      default: ;
    endcase
  end

  logic signed [DATA_W-1:0] a_r, a_i, b_r, b_i, tw_c;
  logic signed [31:0]       rot_r, rot_i;
  logic signed [ACC_W-1:0]  t_r, t_i, sum_r, sum_i, dif_r, dif_i;
  logic signed [DATA_W-1:0] na_r, na_i, nb_r, nb_i;

  always_comb begin
    a_r   = mem_r[p_idx];
    a_i   = mem_i[p_idx];
    b_r   = mem_r[q_idx];
    b_i   = mem_i[q_idx];
    tw_c  = (k_idx == 2'd1) ? C_45 : C_135;
    rot_r = 32'(b_r) * 32'(tw_c) - 32'(b_i) * 32'(C_45) + TW_RND;
    rot_i = 32'(b_r) * 32'(C_45) + 32'(b_i) * 32'(tw_c) + TW_RND;
    case (k_idx)
      2'd0:    begin t_r = ACC_W'(b_r);  t_i = ACC_W'(b_i); end
      2'd2:    begin t_r = -ACC_W'(b_i); t_i = ACC_W'(b_r); end
      default: begin t_r = ACC_W'(rot_r >>> 15); t_i = ACC_W'(rot_i >>> 15); end
    endcase
    sum_r = (ACC_W'(a_r) + t_r + BF_RND) >>> 1;
    sum_i = (ACC_W'(a_i) + t_i + BF_RND) >>> 1;
    dif_r = (ACC_W'(a_r) - t_r + BF_RND) >>> 1;
    dif_i = (ACC_W'(a_i) - t_i + BF_RND) >>> 1;
    na_r  = sat(sum_r);
    na_i  = sat(sum_i);
    nb_r  = sat(dif_r);
    nb_i  = sat(dif_i);
  end

  // NOTE: the sample memory is deliberately not reset; a frame always overwrites it.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && accept) begin
      mem_r[{cnt[0], cnt[1], cnt[2]}] <= bus.in_real;
      mem_i[{cnt[0], cnt[1], cnt[2]}] <= bus.in_imag;
    end else if (state == S_COMPUTE) begin
      mem_r[p_idx] <= na_r;
      mem_i[p_idx] <= na_i;
      mem_r[q_idx] <= nb_r;
      mem_i[q_idx] <= nb_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      stage     <= '0;
      bfly      <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_LOAD: if (accept) begin
          if (load_ok) begin
            cnt   <= '0;
            stage <= '0;
            bfly  <= '0;
          end else if (bus.in_last || cnt == 3'd7) begin
            cnt       <= '0;
            frame_err <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        S_COMPUTE: begin
          bfly <= bfly + 2'd1;
          if (bfly == 2'd3) stage <= stage + 2'd1;
        end
        S_OUTPUT: if (out_fire) begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ifft_8point.sv
// Self-checking bench for ifft_8point: directed test-plan vectors plus random
// frames against a fixed-point IFFT model built from the stage/twiddle rules.
module tb_ifft_8point;
  logic clk = 1'b0;
  logic rst;
  logic done, frame_err;
  always #5 clk = ~clk;

  ifft_8point_if #(.DATA_W(16)) bus ();
  ifft_8point #(.DATA_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .done      (done),
    .frame_err (frame_err)
  );

`ifdef IFFT_ROUND_EN
  localparam int TW_RND = 16384;
  localparam int BF_RND = 1;
`else
  localparam int TW_RND = 0;
  localparam int BF_RND = 0;
`endif

  int total = 0;
  int bad   = 0;
  logic [15:0] vr [8], vi [8];
  logic [15:0] er [8], ei [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Load in bit-reversed order, then three radix-2 stages with W^-k = e^{+j*pi*k/4}.
  function automatic void model();
    int ar [8], ai [8];
    for (int n = 0; n < 8; n++) begin
      int j = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
      ar[j] = int'($signed(vr[n]));
      ai[j] = int'($signed(vi[n]));
    end
    for (int s = 0; s < 3; s++) begin
      int h = 1 << s;
      for (int b = 0; b < 4; b++) begin
        int p = (b / h) * 2 * h + (b % h);
        int q = p + h;
        int k = (b % h) * (4 / h);
        int br = ar[q], bi = ai[q], tr, ti, pr, pi;
        if (k == 0) begin
          tr = br; ti = bi;
        end else if (k == 2) begin
          tr = -bi; ti = br;
        end else begin
          longint c = (k == 1) ? 23170 : -23170;
          longint sn = 23170;
          tr = int'((longint'(br) * c - longint'(bi) * sn + TW_RND) >>> 15);
          ti = int'((longint'(br) * sn + longint'(bi) * c + TW_RND) >>> 15);
        end
        pr = ar[p]; pi = ai[p];
        ar[p] = sat16((pr + tr + BF_RND) >>> 1);
        ai[p] = sat16((pi + ti + BF_RND) >>> 1);
        ar[q] = sat16((pr - tr + BF_RND) >>> 1);
        ai[q] = sat16((pi - ti + BF_RND) >>> 1);
      end
    end
    for (int n = 0; n < 8; n++) begin
      er[n] = 16'(ar[n]);
      ei[n] = 16'(ai[n]);
    end
  endfunction

  // Inputs change at negedge; each task starts and ends at a negedge.
  task automatic send_bins(input int nbins, input int last_pos, input bit gaps);
    for (int i = 0; i < nbins; i++) begin
      int guard = 0;
      if (gaps && $urandom_range(3) == 0) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_real  = vr[i];
      bus.in_imag  = vi[i];
      bus.in_last  = (i == last_pos);
      while (!bus.in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) check("in_ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1..., 2: random ready
  task automatic receive(input int mode);
    int n = 1, idx = 0, cyc = 0;
    bit stalled = 0;
    logic [32:0] held = '0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'd13);
    while (idx < 8 && cyc < 200) begin
      logic rdy;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(1));
      endcase
      bus.out_ready = rdy;
      check("out_valid", 32'(bus.out_valid), 32'd1);
      check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      if (stalled)
        check("hold", 32'({bus.out_real, bus.out_imag}), held[31:0]);
      if (rdy) begin
        check($sformatf("out_real[%0d]", idx), 32'(bus.out_real), 32'(er[idx]));
        check($sformatf("out_imag[%0d]", idx), 32'(bus.out_imag), 32'(ei[idx]));
        check($sformatf("out_last[%0d]", idx), 32'(bus.out_last), 32'(idx == 7));
        idx++;
        stalled = 0;
      end else begin
        held    = {bus.out_last, bus.out_real, bus.out_imag};
        stalled = 1;
      end
      @(negedge clk);
      cyc++;
    end
    if (idx < 8) check("out_timeout", 32'(idx), 32'd8);
    bus.out_ready = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("valid_after", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("done_single", 32'(done), 32'd0);
    check("in_ready_again", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic set_dc();
    for (int n = 0; n < 8; n++) begin vr[n] = 16'h0; vi[n] = 16'h0; end
    vr[0] = 16'h4000;
    for (int n = 0; n < 8; n++) begin er[n] = 16'h0800; ei[n] = 16'h0; end
  endtask

  task automatic set_tone();
    logic [15:0] tr [4], ti [4];
    tr = '{16'h0800, 16'h0000, 16'hF800, 16'h0000};
    ti = '{16'h0000, 16'h0800, 16'h0000, 16'hF800};
    for (int n = 0; n < 8; n++) begin
      vr[n] = 16'h0; vi[n] = 16'h0;
      er[n] = tr[n % 4]; ei[n] = ti[n % 4];
    end
    vr[2] = 16'h4000;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_real = '0; bus.in_imag = '0;
    bus.in_last = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_out_data", 32'({bus.out_real, bus.out_imag}), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);

    // DC bin
    set_dc();
    send_bins(8, 7, 0);
    receive(0);

    // Flat spectrum
    for (int n = 0; n < 8; n++) begin
      vr[n] = 16'h1000; vi[n] = 16'h0; er[n] = 16'h0; ei[n] = 16'h0;
    end
    er[0] = 16'h1000;
    send_bins(8, 7, 0);
    receive(0);

    // Single tone, then the same tone under backpressure
    set_tone();
    send_bins(8, 7, 0);
    receive(0);
    set_tone();
    send_bins(8, 7, 1);
    receive(1);

    // Early in_last on bin 3
    begin
      int seen = 0;
      set_dc();
      send_bins(4, 3, 0);
      check("ferr_early", 32'(frame_err), 32'd1);
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (c == 0) check("ferr_early_once", 32'(frame_err), 32'd0);
        if (bus.out_valid) seen++;
      end
      check("ferr_early_noout", 32'(seen), 32'd0);
    end
    set_dc();
    send_bins(8, 7, 0);
    receive(0);

    // Missing in_last on bin 7
    set_tone();
    send_bins(8, -1, 0);
    check("ferr_nolast", 32'(frame_err), 32'd1);
    @(negedge clk);
    check("ferr_nolast_once", 32'(frame_err), 32'd0);
    set_tone();
    send_bins(8, 7, 0);
    receive(0);

    // Reset during COMPUTE
    begin
      int seen_done = 0, seen_valid = 0;
      set_dc();
      send_bins(8, 7, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      for (int c = 0; c < 20; c++) begin
        if (done) seen_done++;
        if (bus.out_valid) seen_valid++;
        @(negedge clk);
      end
      check("midrst_no_done", 32'(seen_done), 32'd0);
      check("midrst_no_valid", 32'(seen_valid), 32'd0);
    end
    set_tone();
    send_bins(8, 7, 0);
    receive(0);

    // Full-scale frames exercise saturation, then random frames
    for (int n = 0; n < 8; n++) begin vr[n] = 16'h8000; vi[n] = 16'h7FFF; end
    model();
    send_bins(8, 7, 0);
    receive(2);
    for (int n = 0; n < 8; n++) begin vr[n] = (n % 2) ? 16'h8000 : 16'h7FFF; vi[n] = 16'h8000; end
    model();
    send_bins(8, 7, 0);
    receive(2);
    for (int f = 0; f < 25; f++) begin
      for (int n = 0; n < 8; n++) begin
        vr[n] = 16'($urandom);
        vi[n] = 16'($urandom);
      end
      model();
      send_bins(8, 7, 1);
      receive(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
